mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage, directly downstream of the EX/ME pipeline register.
- Consumes that register's outputs and performs the load or store on the data-memory bus using a req/ack handshake.
- Raises stall while a bus access is outstanding.
- Owns the ME/WB pipeline register that feeds writeback: result, destination register and register-write enable.

Parameters:
DBITS, 32, data and address width
REG_INDEX_BIT_WIDTH, 4, register index width
TIMEOUT, 16, WAIT cycles without mem_ack before the access is aborted (>=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wrt_en  in  1  pipeline advance enable from hazard unit
EX_intermediateResult  in  DBITS  ALU result / byte address
EX_regData2  in  DBITS  store data
EX_rd  in  REG_INDEX_BIT_WIDTH  destination register
EX_ME_mux_sel  in  1  1 = load (result from memory), 0 = ALU result
EX_wrReg  in  1  register write enable
EX_wrMem  in  1  memory write enable
mem_req  out  1  bus request, held until ack
mem_we  out  1  1 = store
mem_addr  out  DBITS  byte address (word aligned)
mem_wdata  out  DBITS  store data
mem_ack  in  1  one-cycle bus acknowledge
mem_rdata  in  DBITS  load data, valid with mem_ack
stall  out  1  freeze upstream stages
ME_result  out  DBITS  writeback data
ME_rd  out  REG_INDEX_BIT_WIDTH  writeback register
ME_wrReg  out  1  writeback enable
bus_err  out  1  sticky: timeout occurred
align_err  out  1  sticky: misaligned access

Behaviour:
- Reset (async, immediate): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, ME_result=0, ME_rd=0, ME_wrReg=0, bus_err=0, align_err=0, load_buf=0, timeout counter=0.
- access = EX_wrMem | EX_ME_mux_sel. misaligned = access & (EX_intermediateResult[1:0] != 0).
- FSM, 3 states:
  - IDLE:
    - access & !misaligned -> WAIT.
    - misaligned -> DONE; set align_err; load_buf=0; no bus request issued.
    - No access -> stay IDLE; instruction passes in 1 cycle.
  - WAIT:
    - mem_req=1 (registered, asserted on the cycle after IDLE).
    - mem_we=EX_wrMem; mem_addr/mem_wdata driven from EX inputs, held stable for the whole WAIT.
    - Counter increments each WAIT cycle.
    - mem_ack=1: latch mem_rdata into load_buf, go DONE.
    - Counter reaches TIMEOUT-1 without ack: set bus_err, load_buf=0, go DONE.
    - Ack on the TIMEOUT cycle counts as success.
  - DONE:
    - mem_req=0.
    - wrt_en=1 -> IDLE (counter cleared).
    - wrt_en=0 -> stay DONE; never re-issue the access.
- stall = (IDLE & access) | WAIT. stall=0 in DONE and in IDLE with no access. Combinational from state and inputs.
- ME/WB register, on posedge:
  - wrt_en & !stall: ME_result = EX_ME_mux_sel ? (state==DONE ? load_buf : 0) : EX_intermediateResult; ME_rd=EX_rd; ME_wrReg=EX_wrReg.
  - stall=1: bubble, ME_wrReg<=0 (ME_result/ME_rd hold).
  - wrt_en=0 & !stall: all hold.
- Latency: non-memory instruction 1 cycle. Load/store with ack in first WAIT cycle: 3 cycles (IDLE, WAIT, DONE), stall high for 2.
- A store on a misaligned address or timeout is dropped. The load result is 0 and writeback still occurs if EX_wrReg.
- bus_err and align_err clear only on reset.
- mem_ack outside WAIT is ignored.
- reset during WAIT drops mem_req asynchronously; no retry after reset.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the TIMEOUT default.
- One sub-module mem_stage_ctrl: FSM, timeout counter, error flags, stall/mem_req generation.
- Datapath and ME/WB register reuse the existing Register module (instances for result, rd, wrReg).

Test Plan:
- ALU op: EX_intermediateResult=0x1234, EX_rd=5, EX_wrReg=1, wrt_en=1 -> next edge ME_result=0x1234, ME_rd=5, ME_wrReg=1; stall never high.
- Load: addr 0x40, ME_mux_sel=1, ack after 3 WAIT cycles with rdata 0xDEADBEEF -> mem_req high 3 cycles, mem_addr=0x40, mem_we=0; stall high 4 cycles; then ME_result=0xDEADBEEF.
- Store: addr 0x80, data 0xA5A5A5A5, wrMem=1, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5 for one req cycle; ME_wrReg=0 afterwards; exactly one request.
- Timeout: load, no ack -> mem_req drops after 16 WAIT cycles; bus_err=1; ME_result=0; bus_err stays 1 across later accesses.
- Misaligned load at 0x42 -> no mem_req; align_err=1; one stall cycle; ME_result=0.
- Reset asserted mid-WAIT -> mem_req, stall and ME_wrReg go 0 immediately; the next access after release behaves normally; DONE with wrt_en=0 holds 5 cycles without re-requesting.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding and defaults.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: bus FSM, timeout counter, sticky errors, stall.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DBITS   = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrt_en,
   input  logic [DBITS-1:0] ex_addr,
   input  logic [DBITS-1:0] ex_wdata,
   input  logic             ex_sel,
   input  logic             ex_wrmem,
   input  logic             mem_ack,
   input  logic [DBITS-1:0] mem_rdata,
   output state_t           state,
   output logic             stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [DBITS-1:0] mem_addr,
   output logic [DBITS-1:0] mem_wdata,
   output logic [DBITS-1:0] load_buf,
   output logic             bus_err,
   output logic             align_err
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;
   logic          access;
   logic          misaligned;

   assign access     = ex_wrmem | ex_sel;
   assign misaligned = access & (ex_addr[1:0] != 2'b00);

   // Forced low during reset so upstream is released at once.
   assign stall = ~reset &
                  (((state == IDLE) & access) | (state == WAIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         load_buf  <= '0;
         bus_err   <= 1'b0;
         align_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (misaligned) begin
                  state     <= DONE;
                  align_err <= 1'b1;
                  load_buf  <= '0;
               end else if (access) begin
                  state     <= WAIT;
                  cnt       <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= ex_wrmem;
                  mem_addr  <= ex_addr;
                  mem_wdata <= ex_wdata;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               // An ack on the final cycle still wins over the timeout.
               if (mem_ack) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  load_buf <= mem_rdata;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  bus_err  <= 1'b1;
                  load_buf <= '0;
               end
            end
            DONE: begin
               if (wrt_en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/register.sv
// Generic enable-gated register with asynchronous active-high clear.
module Register #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrt_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         data_out <= '0;
      else if (wrt_en)
         data_out <= data_in;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory access via req/ack plus the ME/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS               = 32,
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int TIMEOUT             = TIMEOUT_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wrt_en,
   input  logic [DBITS-1:0]               EX_intermediateResult,
   input  logic [DBITS-1:0]               EX_regData2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
   input  logic                           EX_ME_mux_sel,
   input  logic                           EX_wrReg,
   input  logic                           EX_wrMem,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [DBITS-1:0]               mem_addr,
   output logic [DBITS-1:0]               mem_wdata,
   input  logic                           mem_ack,
   input  logic [DBITS-1:0]               mem_rdata,
   output logic                           stall,
   output logic [DBITS-1:0]               ME_result,
   output logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
   output logic                           ME_wrReg,
   output logic                           bus_err,
   output logic                           align_err
);

   state_t           state;
   logic [DBITS-1:0] load_buf;
   logic [DBITS-1:0] load_val;
   logic [DBITS-1:0] result_d;
   logic             adv;
   logic             wr_en_q;
   logic             wr_d;

   mem_stage_ctrl #(
      .DBITS   (DBITS),
      .TIMEOUT (TIMEOUT)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .wrt_en    (wrt_en),
      .ex_addr   (EX_intermediateResult),
      .ex_wdata  (EX_regData2),
      .ex_sel    (EX_ME_mux_sel),
      .ex_wrmem  (EX_wrMem),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .state     (state),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .load_buf  (load_buf),
      .bus_err   (bus_err),
      .align_err (align_err)
   );

   assign load_val = (state == DONE) ? load_buf : '0;
   assign result_d = EX_ME_mux_sel ? load_val : EX_intermediateResult;
   assign adv      = wrt_en & ~stall;

   // A stalled cycle still clocks the write-enable so a bubble goes out.
   assign wr_en_q  = wrt_en | stall;
   assign wr_d     = EX_wrReg & ~stall;

   Register #(.WIDTH(DBITS)) u_result (
      .clk      (clk),
      .reset    (reset),
      .wrt_en   (adv),
      .data_in  (result_d),
      .data_out (ME_result)
   );

   Register #(.WIDTH(REG_INDEX_BIT_WIDTH)) u_rd (
      .clk      (clk),
      .reset    (reset),
      .wrt_en   (adv),
      .data_in  (EX_rd),
      .data_out (ME_rd)
   );

   Register #(.WIDTH(1)) u_wrreg (
      .clk      (clk),
      .reset    (reset),
      .wrt_en   (wr_en_q),
      .data_in  (wr_d),
      .data_out (ME_wrReg)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;

   localparam int DB  = 32;
   localparam int RB  = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          wrt_en;
   logic [DB-1:0] EX_intermediateResult;
   logic [DB-1:0] EX_regData2;
   logic [RB-1:0] EX_rd;
   logic          EX_ME_mux_sel;
   logic          EX_wrReg;
   logic          EX_wrMem;
   logic          mem_req;
   logic          mem_we;
   logic [DB-1:0] mem_addr;
   logic [DB-1:0] mem_wdata;
   logic          mem_ack;
   logic [DB-1:0] mem_rdata;
   logic          stall;
   logic [DB-1:0] ME_result;
   logic [RB-1:0] ME_rd;
   logic          ME_wrReg;
   logic          bus_err;
   logic          align_err;

   always #5 clk = ~clk;

   mem_stage #(
      .DBITS               (DB),
      .REG_INDEX_BIT_WIDTH (RB),
      .TIMEOUT             (TMO)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .wrt_en                (wrt_en),
      .EX_intermediateResult (EX_intermediateResult),
      .EX_regData2           (EX_regData2),
      .EX_rd                 (EX_rd),
      .EX_ME_mux_sel         (EX_ME_mux_sel),
      .EX_wrReg              (EX_wrReg),
      .EX_wrMem              (EX_wrMem),
      .mem_req               (mem_req),
      .mem_we                (mem_we),
      .mem_addr              (mem_addr),
      .mem_wdata             (mem_wdata),
      .mem_ack               (mem_ack),
      .mem_rdata             (mem_rdata),
      .stall                 (stall),
      .ME_result             (ME_result),
      .ME_rd                 (ME_rd),
      .ME_wrReg              (ME_wrReg),
      .bus_err               (bus_err),
      .align_err             (align_err)
   );

   int tests = 0;
   int fails = 0;

   logic m_be;
   logic m_ae;

   int            o_stalls;
   int            o_reqs;
   logic          o_we;
   logic          o_hung;
   logic [DB-1:0] o_addr;
   logic [DB-1:0] o_wdata;

   typedef struct {
      int            stalls;
      int            reqs;
      logic [DB-1:0] res;
      logic          be;
      logic          ae;
   } exp_t;

   // One instruction's visible effect, from the access rules alone.
   function automatic exp_t model(input logic [DB-1:0] addr,
                                  input logic [DB-1:0] rdata,
                                  input logic sel, input logic wm,
                                  input int ack_at);
      exp_t e;
      bit   acc;
      e.stalls = 0;
      e.reqs   = 0;
      e.res    = addr;
      e.be     = 1'b0;
      e.ae     = 1'b0;
      acc      = sel | wm;
      if (acc && addr[1:0] != 2'b00) begin
         e.stalls = 1;
         e.ae     = 1'b1;
         if (sel) e.res = '0;
      end else if (acc) begin
         if (ack_at >= 1 && ack_at <= TMO) begin
            e.reqs   = ack_at;
            e.stalls = ack_at + 1;
            if (sel) e.res = rdata;
         end else begin
            e.reqs   = TMO;
            e.stalls = TMO + 1;
            e.be     = 1'b1;
            if (sel) e.res = '0;
         end
      end
      return e;
   endfunction

   // Drives one instruction to commit; caller is just after a negedge.
   task automatic exec(input logic [DB-1:0] addr, input logic [DB-1:0] wdata,
                       input logic [RB-1:0] rd, input logic sel,
                       input logic wr, input logic wm, input int ack_at,
                       input logic [DB-1:0] rdata, input logic noise);
      int n;
      bit fin;
      EX_intermediateResult = addr;
      EX_regData2           = wdata;
      EX_rd                 = rd;
      EX_ME_mux_sel         = sel;
      EX_wrReg              = wr;
      EX_wrMem              = wm;
      wrt_en                = 1'b1;
      o_stalls = 0;
      o_reqs   = 0;
      o_we     = 1'b0;
      o_addr   = '0;
      o_wdata  = '0;
      fin      = 0;
      n        = 0;
      while (!fin && n < 64) begin
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (stall) o_stalls++;
         if (mem_req) begin
            o_reqs++;
            o_we    = mem_we;
            o_addr  = mem_addr;
            o_wdata = mem_wdata;
            if (o_reqs == ack_at) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
         end else begin
            mem_ack = noise;
         end
         if (!stall) fin = 1;
         @(negedge clk);
         n++;
      end
      mem_ack = 1'b0;
      o_hung  = !fin;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; wrt_en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      EX_intermediateResult = '0; EX_regData2 = '0; EX_rd = '0;
      EX_ME_mux_sel = 1'b0; EX_wrReg = 1'b0; EX_wrMem = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({mem_req, mem_we, stall, ME_wrReg, bus_err, align_err} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctl: got %b expected 000000",
                  {mem_req, mem_we, stall, ME_wrReg, bus_err, align_err});
      end
      tests++;
      if (mem_addr !== '0 || mem_wdata !== '0 || ME_result !== '0 || ME_rd !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h %h %h %h expected all zero",
                  mem_addr, mem_wdata, ME_result, ME_rd);
      end
      reset = 1'b0;
      m_be = 1'b0;
      m_ae = 1'b0;
   endtask

   task automatic test_alu();
      exec(32'h1234, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
      tests++;
      if (ME_result !== 32'h1234 || ME_rd !== 4'd5 || ME_wrReg !== 1'b1) begin
         fails++;
         $display("FAIL alu_wb: got %h/%0d/%b expected 1234/5/1",
                  ME_result, ME_rd, ME_wrReg);
      end
      tests++;
      if (o_stalls != 0 || o_reqs != 0 || o_hung) begin
         fails++;
         $display("FAIL alu_timing: got stalls=%0d reqs=%0d expected 0/0",
                  o_stalls, o_reqs);
      end
   endtask

   task automatic test_load();
      exec(32'h40, 32'h0, 4'd3, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF, 1'b0);
      tests++;
      if (o_reqs != 3 || o_stalls != 4 || o_hung) begin
         fails++;
         $display("FAIL load_timing: got reqs=%0d stalls=%0d expected 3/4",
                  o_reqs, o_stalls);
      end
      tests++;
      if (o_addr !== 32'h40 || o_we !== 1'b0) begin
         fails++;
         $display("FAIL load_bus: got addr=%h we=%b expected 40/0", o_addr, o_we);
      end
      tests++;
      if (ME_result !== 32'hDEADBEEF || ME_rd !== 4'd3 || ME_wrReg !== 1'b1) begin
         fails++;
         $display("FAIL load_wb: got %h/%0d/%b expected deadbeef/3/1",
                  ME_result, ME_rd, ME_wrReg);
      end
   endtask

   task automatic test_store();
      exec(32'h80, 32'hA5A5A5A5, 4'd2, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b1);
      tests++;
      if (o_reqs != 1 || o_stalls != 2 || o_we !== 1'b1 || o_hung) begin
         fails++;
         $display("FAIL store_timing: got reqs=%0d stalls=%0d we=%b expected 1/2/1",
                  o_reqs, o_stalls, o_we);
      end
      tests++;
      if (o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h80) begin
         fails++;
         $display("FAIL store_bus: got %h@%h expected a5a5a5a5@80", o_wdata, o_addr);
      end
      tests++;
      if (ME_wrReg !== 1'b0) begin
         fails++;
         $display("FAIL store_wb: got wrReg=%b expected 0", ME_wrReg);
      end
   endtask

   task automatic test_timeout();
      exec(32'h100, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      m_be = 1'b1;
      tests++;
      if (o_reqs != TMO || o_stalls != TMO + 1 || o_hung) begin
         fails++;
         $display("FAIL timeout_timing: got reqs=%0d stalls=%0d expected %0d/%0d",
                  o_reqs, o_stalls, TMO, TMO + 1);
      end
      tests++;
      if (bus_err !== 1'b1 || ME_result !== '0 || ME_wrReg !== 1'b1) begin
         fails++;
         $display("FAIL timeout_wb: got err=%b res=%h wr=%b expected 1/0/1",
                  bus_err, ME_result, ME_wrReg);
      end
      exec(32'h104, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, TMO, 32'h600D, 1'b0);
      tests++;
      if (bus_err !== 1'b1 || ME_result !== 32'h600D || o_reqs != TMO) begin
         fails++;
         $display("FAIL timeout_edge_ack: got err=%b res=%h reqs=%0d expected 1/600d/%0d",
                  bus_err, ME_result, o_reqs, TMO);
      end
   endtask

   task automatic test_misaligned();
      exec(32'h42, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1, 32'h1111, 1'b0);
      m_ae = 1'b1;
      tests++;
      if (o_reqs != 0 || o_stalls != 1 || o_hung) begin
         fails++;
         $display("FAIL misalign_timing: got reqs=%0d stalls=%0d expected 0/1",
                  o_reqs, o_stalls);
      end
      tests++;
      if (align_err !== 1'b1 || ME_result !== '0 || ME_wrReg !== 1'b1) begin
         fails++;
         $display("FAIL misalign_wb: got err=%b res=%h wr=%b expected 1/0/1",
                  align_err, ME_result, ME_wrReg);
      end
   endtask

   task automatic test_hold();
      int reqs;
      int stalls;
      reqs   = 0;
      stalls = 0;
      EX_intermediateResult = 32'h200; EX_rd = 4'd7;
      EX_ME_mux_sel = 1'b1; EX_wrReg = 1'b1; EX_wrMem = 1'b0;
      wrt_en = 1'b0;
      #1;
      @(negedge clk);
      #1;
      if (mem_req) begin
         reqs++;
         mem_ack   = 1'b1;
         mem_rdata = 32'hCAFEF00D;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (mem_req) reqs++;
         if (stall) stalls++;
         @(negedge clk);
      end
      #1;
      tests++;
      if (reqs != 1 || stalls != 0 || ME_wrReg !== 1'b0) begin
         fails++;
         $display("FAIL done_hold: got reqs=%0d stalls=%0d wr=%b expected 1/0/0",
                  reqs, stalls, ME_wrReg);
      end
      wrt_en = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (ME_result !== 32'hCAFEF00D || ME_rd !== 4'd7 || ME_wrReg !== 1'b1) begin
         fails++;
         $display("FAIL done_release: got %h/%0d/%b expected cafef00d/7/1",
                  ME_result, ME_rd, ME_wrReg);
      end
   endtask

   task automatic test_random(input int count);
      exp_t          e;
      logic [DB-1:0] addr;
      logic [DB-1:0] wdata;
      logic [DB-1:0] rdata;
      logic [RB-1:0] rd;
      logic          sel;
      logic          wm;
      logic          wr;
      int            ack_at;
      int            kind;
      for (int i = 0; i < count; i++) begin
         kind  = $urandom_range(0, 3);
         addr  = $urandom;
         addr[1:0] = 2'b00;
         wdata = $urandom;
         rdata = $urandom;
         rd    = RB'($urandom_range(0, 15));
         wr    = 1'($urandom_range(0, 1));
         sel   = 1'b0;
         wm    = 1'b0;
         case (kind)
            1: sel = 1'b1;
            2: wm = 1'b1;
            3: begin
               sel = 1'($urandom_range(0, 1));
               wm  = ~sel;
               addr[1:0] = 2'($urandom_range(1, 3));
            end
            default: ;
         endcase
         ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
         e = model(addr, rdata, sel, wm, ack_at);
         m_be = m_be | e.be;
         m_ae = m_ae | e.ae;
         exec(addr, wdata, rd, sel, wr, wm, ack_at, rdata, 1'($urandom_range(0, 1)));
         tests++;
         if (o_hung || o_stalls != e.stalls || o_reqs != e.reqs) begin
            fails++;
            $display("FAIL rnd%0d_timing: got stalls=%0d reqs=%0d expected %0d/%0d",
                     i, o_stalls, o_reqs, e.stalls, e.reqs);
         end
         tests++;
         if (ME_result !== e.res || ME_rd !== rd || ME_wrReg !== wr) begin
            fails++;
            $display("FAIL rnd%0d_wb: got %h/%0d/%b expected %h/%0d/%b",
                     i, ME_result, ME_rd, ME_wrReg, e.res, rd, wr);
         end
         tests++;
         if (bus_err !== m_be || align_err !== m_ae) begin
            fails++;
            $display("FAIL rnd%0d_flags: got be=%b ae=%b expected %b/%b",
                     i, bus_err, align_err, m_be, m_ae);
         end
         if (e.reqs > 0) begin
            tests++;
            if (o_addr !== addr || o_we !== wm || o_wdata !== wdata) begin
               fails++;
               $display("FAIL rnd%0d_bus: got %h/%b/%h expected %h/%b/%h",
                        i, o_addr, o_we, o_wdata, addr, wm, wdata);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      EX_intermediateResult = 32'h300; EX_rd = 4'd6;
      EX_ME_mux_sel = 1'b1; EX_wrReg = 1'b1; EX_wrMem = 1'b0;
      wrt_en = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || ME_wrReg !== 1'b0 || bus_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got req=%b stall=%b wr=%b be=%b expected 0000",
                  mem_req, stall, ME_wrReg, bus_err);
      end
      EX_ME_mux_sel = 1'b0;
      EX_wrMem      = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_be  = 1'b0;
      m_ae  = 1'b0;
      #1;
      exec(32'h304, 32'h0, 4'd8, 1'b1, 1'b1, 1'b0, 2, 32'h0BADF00D, 1'b0);
      tests++;
      if (o_reqs != 2 || o_stalls != 3 || ME_result !== 32'h0BADF00D || o_addr !== 32'h304) begin
         fails++;
         $display("FAIL after_reset: got reqs=%0d stalls=%0d res=%h addr=%h expected 2/3/0badf00d/304",
                  o_reqs, o_stalls, ME_result, o_addr);
      end
      test_random(8);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_timeout();
      test_misaligned();
      test_hold();
      test_random(40);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
